mem_access_unit: RTL and testbench

Responder end of the load/store request that the decode stage produces (mtype, mem_rw, width, rdtype, write data).
- Accepts one request from the EX/MEM pipeline register.
- Runs one word-wide transaction on a single-port data bus.
- Aligns and extends load data.
- Drives the Dcache stall flag consumed by flow control.

---
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the memory access unit (master) and the
// single-port data memory / Dcache (slave). One word-wide transaction at
// a time: request level held until ack, read data valid with ack.
interface mem_access_unit_if;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [3:0]  bus_be_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;

   modport master (
      output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
      input  bus_ack_i, bus_rdata_i
   );

   modport slave (
      input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
      output bus_ack_i, bus_rdata_i
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit: takes one load/store from EX/MEM, runs a single
// word-wide bus transaction, aligns/extends load data and drives the
// Dcache stall flag for flow control.
// Optional feature macro: MAU_TIMEOUT_EN (abort BUSY after TIMEOUT_CYCLES
// cycles without ack and pulse mau_bus_err_o).
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_mtype_i,
   input  logic                     req_mem_rw_i,
   input  logic [1:0]               req_mem_width_i,
   input  logic                     req_rdtype_i,
   input  logic [31:0]              req_addr_i,
   input  logic [31:0]              req_wr_data_i,
   output logic                     mau_stall_flag_o,
   output logic [31:0]              mau_rd_data_o,
   output logic                     mau_rd_valid_o,
   output logic                     mau_misalign_o,
   output logic                     mau_bus_err_o,
   mem_access_unit_if.master        bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic        rw_q;
   logic [1:0]  width_q;
   logic        rdtype_q;
   logic [1:0]  off_q;
   logic        accept;
   logic        req_bad;
   logic        tmo_hit;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] ld_data;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and stall flag; DONE never re-accepts the served request.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_d          = state_q;
      accept           = 1'b0;
      mau_stall_flag_o = 1'b0;
      case (state_q)
         IDLE: begin
            accept           = req_mtype_i;
            mau_stall_flag_o = req_mtype_i;
            if (req_mtype_i) state_d = req_bad ? DONE : BUSY;
         end
         BUSY: begin
            mau_stall_flag_o = 1'b1;
            if (bus.bus_ack_i || tmo_hit) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Alignment check and store lane placement from the live request.
   always_comb begin
      req_bad  = 1'b0;
      st_be    = 4'b0000;
      st_wdata = req_wr_data_i;
      case (req_mem_width_i)
         2'd1: begin
            st_be    = 4'b0001 << req_addr_i[1:0];
            st_wdata = {4{req_wr_data_i[7:0]}};
         end
         2'd2: begin
            req_bad  = req_addr_i[0];
            st_be    = req_addr_i[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{req_wr_data_i[15:0]}};
         end
         2'd3: begin
            req_bad  = (req_addr_i[1:0] != 2'b00);
            st_be    = 4'b1111;
         end
         default: req_bad = 1'b1;
      endcase
   end

   // Load lane select and sign/zero extension from the captured request.
   always_comb begin
      ld_b = bus.bus_rdata_i[{off_q, 3'b000} +: 8];
      ld_h = bus.bus_rdata_i[{off_q[1], 4'b0000} +: 16];
      case (width_q)
         2'd1:    ld_data = rdtype_q ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
         2'd2:    ld_data = rdtype_q ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
         default: ld_data = bus.bus_rdata_i;
      endcase
   end

`ifdef MAU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                          $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] tmo_cnt_q;

   assign tmo_hit = (state_q == BUSY) && !bus.bus_ack_i &&
                    (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // BUSY-cycle counter and bus error pulse; ack has priority over timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q     <= '0;
         mau_bus_err_o <= 1'b0;
      end else begin
         mau_bus_err_o <= tmo_hit;
         if (accept && !req_bad)                          tmo_cnt_q <= '0;
         else if (state_q == BUSY && !bus.bus_ack_i)      tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end
`else
   assign tmo_hit       = 1'b0;
   // Without the timeout the parameter has no effect; the flag is constant 0.
   assign mau_bus_err_o = (TIMEOUT_CYCLES < 0);
`endif

   // Request capture, bus drive and result/pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rw_q            <= 1'b0;
         width_q         <= 2'd0;
         rdtype_q        <= 1'b0;
         off_q           <= 2'd0;
         bus.bus_req_o   <= 1'b0;
         bus.bus_we_o    <= 1'b0;
         bus.bus_addr_o  <= 32'h0;
         bus.bus_wdata_o <= 32'h0;
         bus.bus_be_o    <= 4'h0;
         mau_rd_data_o   <= 32'h0;
         mau_rd_valid_o  <= 1'b0;
         mau_misalign_o  <= 1'b0;
      end else begin
         mau_rd_valid_o <= 1'b0;
         mau_misalign_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  rw_q     <= req_mem_rw_i;
                  width_q  <= req_mem_width_i;
                  rdtype_q <= req_rdtype_i;
                  off_q    <= req_addr_i[1:0];
                  if (req_bad) begin
                     mau_misalign_o <= 1'b1;
                     if (req_mem_rw_i) mau_rd_data_o <= 32'h0;
                  end else begin
                     bus.bus_req_o   <= 1'b1;
                     bus.bus_we_o    <= ~req_mem_rw_i;
                     bus.bus_addr_o  <= {req_addr_i[31:2], 2'b00};
                     bus.bus_wdata_o <= st_wdata;
                     bus.bus_be_o    <= req_mem_rw_i ? 4'b1111 : st_be;
                  end
               end
            end
            BUSY: begin
               if (bus.bus_ack_i) begin
                  bus.bus_req_o <= 1'b0;
                  if (rw_q) begin
                     mau_rd_data_o  <= ld_data;
                     mau_rd_valid_o <= 1'b1;
                  end
               end else if (tmo_hit) begin
                  bus.bus_req_o <= 1'b0;
                  if (rw_q) mau_rd_data_o <= 32'h0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model predicts
// every output per cycle and one compare process checks it at negedge.
module tb_mem_access_unit;
`ifdef MAU_TIMEOUT_EN
   localparam int TMO = 4;
`else
   localparam int TMO = 255;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_mtype, req_rw, req_rdtype;
   logic [1:0]  req_width;
   logic [31:0] req_addr, req_wdata;
   logic        stall, rd_valid, misalign, bus_err;
   logic [31:0] rd_data;

   mem_access_unit_if bus_if ();

   mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_mtype_i      (req_mtype),
      .req_mem_rw_i     (req_rw),
      .req_mem_width_i  (req_width),
      .req_rdtype_i     (req_rdtype),
      .req_addr_i       (req_addr),
      .req_wr_data_i    (req_wdata),
      .mau_stall_flag_o (stall),
      .mau_rd_data_o    (rd_data),
      .mau_rd_valid_o   (rd_valid),
      .mau_misalign_o   (misalign),
      .mau_bus_err_o    (bus_err),
      .bus              (bus_if)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic        chk_en = 1'b0;
   logic        chk_bus, chk_wdata;
   logic        exp_stall, exp_req, exp_valid, exp_mis, exp_err, exp_we;
   logic [31:0] exp_rd_data, exp_addr, exp_wdata;
   logic [3:0]  exp_be;

   logic        prev_req = 1'b0;
   int          req_rises = 0;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;
   logic        last_we;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int unsigned m_size(input logic [1:0] w);
      return (w == 2'd0) ? 0 : (1 << (int'(w) - 1));
   endfunction

   function automatic bit m_bad(input logic [1:0] w, input logic [31:0] a);
      int unsigned sz = m_size(w);
      return (sz == 0) || ((a % sz) != 0);
   endfunction

   function automatic logic [3:0] m_be(input logic rw, input logic [1:0] w, input logic [31:0] a);
      int unsigned sz = m_size(w);
      if (rw || sz == 4) return 4'hF;
      return 4'(((1 << sz) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] d);
      case (m_size(w))
         1:       return (d & 32'hFF) * 32'h01010101;
         2:       return (d & 32'hFFFF) * 32'h00010001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] w, input logic rdt,
                                          input logic [31:0] a, input logic [31:0] rdata);
      int unsigned nb = 8 * m_size(w);
      logic [31:0] mask, v;
      if (nb == 32) return rdata;
      mask = (32'h1 << nb) - 1;
      v    = (rdata >> (8 * (a % 4))) & mask;
      if (!rdt && v[nb-1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("stall",    {31'b0, stall},            {31'b0, exp_stall});
         check("bus_req",  {31'b0, bus_if.bus_req_o}, {31'b0, exp_req});
         check("rd_valid", {31'b0, rd_valid},         {31'b0, exp_valid});
         check("misalign", {31'b0, misalign},         {31'b0, exp_mis});
         check("bus_err",  {31'b0, bus_err},          {31'b0, exp_err});
         check("rd_data",  rd_data,                   exp_rd_data);
         if (chk_bus) begin
            check("bus_addr", bus_if.bus_addr_o,         exp_addr);
            check("bus_we",   {31'b0, bus_if.bus_we_o},  {31'b0, exp_we});
            check("bus_be",   {28'b0, bus_if.bus_be_o},  {28'b0, exp_be});
            if (chk_wdata) check("bus_wdata", bus_if.bus_wdata_o, exp_wdata);
         end
      end
      if (bus_if.bus_req_o) begin
         last_addr  = bus_if.bus_addr_o;
         last_wdata = bus_if.bus_wdata_o;
         last_be    = bus_if.bus_be_o;
         last_we    = bus_if.bus_we_o;
         if (!prev_req) req_rises++;
      end
      prev_req = bus_if.bus_req_o;
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle_exp();
      exp_stall = 1'b0; exp_req = 1'b0; exp_valid = 1'b0;
      exp_mis   = 1'b0; exp_err = 1'b0;
      chk_bus   = 1'b0; chk_wdata = 1'b0;
   endtask

   task automatic clear_req();
      req_mtype = 1'b0; req_rw = 1'b0; req_width = 2'd0; req_rdtype = 1'b0;
      req_addr  = 32'h0; req_wdata = 32'h0;
   endtask

   task automatic idle(input int n, input logic ack_noise);
      for (int i = 0; i < n; i++) begin
         step();
         clear_req();
         bus_if.bus_ack_i   = ack_noise;
         bus_if.bus_rdata_i = 32'h5A5A5A5A;
         set_idle_exp();
      end
   endtask

   // Accept cycle, ack_after BUSY cycles (0 = never ack), then DONE.
   // Returns in the DONE cycle with the served request still on the inputs.
   task automatic txn(input logic rw, input logic [1:0] w, input logic rdt,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int ack_after, input logic [31:0] rdata);
      int n_busy;
      step();
      req_mtype = 1'b1; req_rw = rw; req_width = w; req_rdtype = rdt;
      req_addr  = a;    req_wdata = wd;
      bus_if.bus_ack_i = 1'b0;
      set_idle_exp();
      exp_stall = 1'b1;
      if (m_bad(w, a)) begin
         step();
         set_idle_exp();
         exp_mis = 1'b1;
         if (rw) exp_rd_data = 32'h0;
      end else begin
         n_busy = (ack_after > 0) ? ack_after : TMO;
         for (int k = 1; k <= n_busy; k++) begin
            step();
            bus_if.bus_ack_i   = (k == ack_after);
            bus_if.bus_rdata_i = (k == ack_after) ? rdata : 32'hDEADBEEF;
            set_idle_exp();
            exp_stall = 1'b1;
            exp_req   = 1'b1;
            chk_bus   = 1'b1;
            exp_addr  = {a[31:2], 2'b00};
            exp_we    = ~rw;
            exp_be    = m_be(rw, w, a);
            chk_wdata = ~rw;
            exp_wdata = m_wdata(w, wd);
         end
         step();
         bus_if.bus_ack_i = 1'b0;
         set_idle_exp();
         if (ack_after > 0) begin
            exp_valid = rw;
            if (rw) exp_rd_data = m_load(w, rdt, a, rdata);
         end else begin
            exp_err = 1'b1;
            if (rw) exp_rd_data = 32'h0;
         end
      end
   endtask

   initial begin
      int r0;
      rst = 1'b1;
      clear_req();
      bus_if.bus_ack_i   = 1'b0;
      bus_if.bus_rdata_i = 32'h0;
      set_idle_exp();
      exp_rd_data = 32'h0;

      // Reset state, including bus fields.
      step();
      step();
      chk_en    = 1'b1;
      chk_bus   = 1'b1;
      chk_wdata = 1'b1;
      exp_addr  = 32'h0; exp_wdata = 32'h0; exp_be = 4'h0; exp_we = 1'b0;
      step();
      rst = 1'b0;
      set_idle_exp();
      idle(2, 1'b1);   // stray acks while idle are ignored
      idle(1, 1'b0);

      // Load byte signed.
      txn(1'b1, 2'd1, 1'b0, 32'h1003, 32'h0, 1, 32'h80AABBCC);
      @(negedge clk);
      check("lit_ldb_data", rd_data, 32'hFFFFFF80);
      check("lit_ldb_addr", last_addr, 32'h00001000);
      idle(1, 1'b0);

      // Load half unsigned, then signed.
      txn(1'b1, 2'd2, 1'b1, 32'h2002, 32'h0, 1, 32'hF00D1234);
      @(negedge clk);
      check("lit_ldhu_data", rd_data, 32'h0000F00D);
      idle(1, 1'b0);
      txn(1'b1, 2'd2, 1'b0, 32'h2002, 32'h0, 1, 32'hF00D1234);
      @(negedge clk);
      check("lit_ldhs_data", rd_data, 32'hFFFFF00D);
      idle(1, 1'b0);

      // Store byte with three BUSY cycles.
      txn(1'b0, 2'd1, 1'b0, 32'h3001, 32'h000000A5, 3, 32'h0);
      @(negedge clk);
      check("lit_stb_be",    {28'b0, last_be}, 32'h2);
      check("lit_stb_wdata", last_wdata, 32'hA5A5A5A5);
      check("lit_stb_we",    {31'b0, last_we}, 32'h1);
      idle(1, 1'b0);

      // Misaligned word load.
      txn(1'b1, 2'd3, 1'b0, 32'h4002, 32'h0, 1, 32'h0);
      @(negedge clk);
      check("lit_mis_pulse", {31'b0, misalign}, 32'h1);
      check("lit_mis_data",  rd_data, 32'h0);
      idle(1, 1'b0);

      // Back-to-back store word then load word.
      r0 = req_rises;
      txn(1'b0, 2'd3, 1'b0, 32'h5000, 32'h12345678, 1, 32'h0);
      txn(1'b1, 2'd3, 1'b0, 32'h5004, 32'h0, 1, 32'hCAFEF00D);
      @(negedge clk);
      check("lit_b2b_count", req_rises - r0, 32'd2);
      check("lit_b2b_data",  rd_data, 32'hCAFEF00D);
      idle(1, 1'b0);

      // More lanes and illegal forms.
      txn(1'b0, 2'd2, 1'b0, 32'h7002, 32'h0000BEEF, 2, 32'h0);
      txn(1'b1, 2'd1, 1'b1, 32'h7000, 32'h0, 1, 32'h123456F1);
      txn(1'b0, 2'd0, 1'b0, 32'h7000, 32'h11111111, 1, 32'h0);
      txn(1'b1, 2'd2, 1'b0, 32'h7001, 32'h0, 1, 32'h0);
      txn(1'b1, 2'd2, 1'b0, 32'h7000, 32'h0, 2, 32'h00008001);
      idle(2, 1'b0);

`ifdef MAU_TIMEOUT_EN
      txn(1'b1, 2'd3, 1'b0, 32'h8000, 32'h0, 0, 32'h0);
      @(negedge clk);
      check("lit_tmo_err", {31'b0, bus_err}, 32'h1);
      idle(2, 1'b0);
`endif

      // Reset during BUSY; a later ack must be ignored.
      txn(1'b1, 2'd3, 1'b0, 32'h6000, 32'h0, 1, 32'h0BADF00D);
      step();
      req_mtype = 1'b1; req_rw = 1'b1; req_width = 2'd3; req_addr = 32'h6000;
      set_idle_exp();
      exp_stall = 1'b1;
      step();
      bus_if.bus_ack_i = 1'b0;
      set_idle_exp();
      exp_stall = 1'b1; exp_req = 1'b1; chk_bus = 1'b1;
      exp_addr = 32'h6000; exp_we = 1'b0; exp_be = 4'hF;
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_req();
      set_idle_exp();
      exp_rd_data = 32'h0;
      chk_bus = 1'b1; chk_wdata = 1'b1;
      exp_addr = 32'h0; exp_wdata = 32'h0; exp_be = 4'h0; exp_we = 1'b0;
      step();
      bus_if.bus_ack_i   = 1'b1;
      bus_if.bus_rdata_i = 32'hFFFFFFFF;
      set_idle_exp();
      idle(2, 1'b0);
      @(negedge clk);
      check("lit_rst_data", rd_data, 32'h0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
